moving_avg_ctrl: RTL and testbench
==================================

MOVING_AVG_CTRL -- requirements
Module: moving_avg_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: sample width, unsigned.
REQ-002 SHALL have parameter WIN_LOG2, default 4: window length N = 2^WIN_LOG2, range 1..8.
REQ-003 SHALL have parameter FIFO_ADDR_WIDTH, default 5: external FIFO address width; elaboration error unless FIFO_ADDR_WIDTH >= WIN_LOG2+1.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 din  in  DATA_WIDTH  input sample.
REQ-008 din_valid  in  1  din qualifier.
REQ-009 din_ready  out  1  sample accepted when din_valid & din_ready.
REQ-010 clear  in  1  synchronous request to empty the window.
REQ-011 dout  out  DATA_WIDTH  window average.
REQ-012 dout_valid  out  1  one-cycle pulse qualifying dout.
REQ-013 fifo_din  out  DATA_WIDTH  FIFO write data.
REQ-014 fifo_wr_en  out  1  FIFO write strobe.
REQ-015 fifo_rd_en  out  1  FIFO read strobe.
REQ-016 fifo_dout  in  DATA_WIDTH  FIFO head data, first-word-fall-through (valid whenever fifo_empty=0).
REQ-017 fifo_full, fifo_empty  in  1 each  FIFO status flags.
REQ-018 err  out  1  sticky underflow error.

Function
REQ-019 SHALL implement states FILL, RUN, FLUSH; reset state FILL.
REQ-020 SHALL keep cnt (WIN_LOG2+1 bits) = samples stored, and sum (DATA_WIDTH+WIN_LOG2 bits, unsigned, never overflows).
REQ-021 din_ready SHALL be 1 in FILL and RUN when fifo_full=0 and clear=0; 0 in FLUSH.
REQ-022 FILL, accepted sample: fifo_wr_en=1, fifo_din=din, fifo_rd_en=0, sum += din, cnt += 1.
REQ-023 FILL, accepted sample with cnt=N-1: additionally dout_valid=1 next cycle; next state RUN.
REQ-024 RUN, accepted sample: same cycle fifo_rd_en=1 and fifo_wr_en=1 (fifo_din=din); sum <= sum + din - fifo_dout; cnt unchanged at N.
REQ-025 RUN: every accepted sample SHALL produce dout_valid=1 exactly one cycle later.
REQ-026 dout SHALL be registered: dout = sum_next >> WIN_LOG2 (truncating), updated only when dout_valid asserts, held otherwise.
REQ-027 No FIFO strobe SHALL assert in any cycle without an accepted sample, except in FLUSH.
REQ-028 clear=1 in FILL/RUN: no sample accepted that cycle; next state FLUSH; sum and cnt cleared.
REQ-029 FLUSH: fifo_rd_en = ~fifo_empty each cycle; on fifo_empty=1 go to FILL next cycle; clear held high keeps FLUSH.
REQ-030 In RUN, if fifo_empty=1 when a read is required, err SHALL set and remain set until reset; sum still updated with fifo_dout treated as 0.
REQ-031 din_valid gaps SHALL not alter state, sum, cnt or FIFO strobes.

Reset
REQ-032 rst_n=0 SHALL immediately force state FILL, cnt=0, sum=0, dout=0, dout_valid=0, err=0, fifo_wr_en=0, fifo_rd_en=0, din_ready=0.
REQ-033 din_ready SHALL return to 1 on the first clock edge after rst_n deasserts.
REQ-034 The external FIFO SHALL be reset together with this block; reset mid-RUN discards all window content.

Verification (DATA_WIDTH=8, WIN_LOG2=2, FIFO_ADDR_WIDTH=3)
REQ-035 Feed 1,2,3,4 back-to-back -> dout_valid only after the 4th sample, dout=2 (10>>2); 4 FIFO writes, 0 reads.
REQ-036 Continue with 8,12 -> dout=4 (17>>2) then 6 (27>>2); each cycle fifo_rd_en=fifo_wr_en=1.
REQ-037 Feed 255 x6 -> dout=255 from the 4th output onward; sum peaks at 1020 with no wrap.
REQ-038 Pulse clear in RUN with 4 stored -> din_ready=0, exactly 4 fifo_rd_en pulses, return to FILL; next 4,4,4,4 -> dout=4.
REQ-039 Assert rst_n=0 mid-RUN with din_valid=1 -> all outputs 0 asynchronously; after release, 3 samples give no dout_valid.
REQ-040 Random din_valid gaps (50%) on a 200-sample stream -> dout matches reference model of floor(sum of last 4 / 4); err stays 0.

Source files
------------

// File: rtl/moving_avg_ctrl_if.sv
// Stream and external-FIFO signal bundle for the moving-average controller.
// Handshake: a sample transfers on a rising clk edge where din_valid && din_ready;
// din_valid may be raised or dropped freely, din_ready never waits on din_valid.
// dout_valid is a one-cycle pulse with no back-pressure.
interface moving_avg_ctrl_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] din;
   logic                  din_valid;
   logic                  din_ready;
   logic                  clear;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic [DATA_WIDTH-1:0] fifo_din;
   logic                  fifo_wr_en;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  err;

   // Controller side
   modport slave (
      input  din, din_valid, clear, fifo_dout, fifo_full, fifo_empty,
      output din_ready, dout, dout_valid, fifo_din, fifo_wr_en, fifo_rd_en, err
   );

   // Source / FIFO / sink side
   modport master (
      output din, din_valid, clear, fifo_dout, fifo_full, fifo_empty,
      input  din_ready, dout, dout_valid, fifo_din, fifo_wr_en, fifo_rd_en, err
   );
endinterface

// File: rtl/moving_avg_ctrl.sv
// Moving average over the last 2^WIN_LOG2 samples. Window samples live in an
// external first-word-fall-through FIFO; this block keeps a running sum and
// count, pushing each new sample and popping the oldest once the window is full.
module moving_avg_ctrl #(
   parameter int DATA_WIDTH      = 8,
   parameter int WIN_LOG2        = 4,
   parameter int FIFO_ADDR_WIDTH = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   moving_avg_ctrl_if.slave    bus,
   output logic [1:0]          dbg_state
);

   localparam int N  = 1 << WIN_LOG2;
   localparam int CW = WIN_LOG2 + 1;
   localparam int SW = DATA_WIDTH + WIN_LOG2;

   generate
      if (FIFO_ADDR_WIDTH < WIN_LOG2 + 1) begin : g_bad_fifo_aw
         $error("moving_avg_ctrl: FIFO_ADDR_WIDTH must be >= WIN_LOG2+1");
      end
      if (WIN_LOG2 < 1 || WIN_LOG2 > 8) begin : g_bad_win
         $error("moving_avg_ctrl: WIN_LOG2 must be in 1..8");
      end
   endgenerate

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [SW-1:0]         sum_q, sum_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  dout_valid_q, dout_valid_d;
   logic                  err_q, err_d;
   logic                  ready_en_q, ready_en_d;

   logic                  din_ready;
   logic                  accept;
   logic [DATA_WIDTH-1:0] oldest;

   // Ready is held off for the first edge after reset so the FIFO leaves reset first
   assign din_ready = ready_en_q & (state_q != FLUSH) & ~bus.fifo_full & ~bus.clear;
   assign accept    = bus.din_valid & din_ready;
   // An empty FIFO in RUN is an underflow; treat the missing sample as zero
   assign oldest    = bus.fifo_empty ? '0 : bus.fifo_dout;

   assign bus.din_ready  = din_ready;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.err        = err_q;
   assign dbg_state      = state_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FILL;
      else        state_q <= state_d;
   end

   // Next-state logic: clear wins over any sample, flush drains until empty
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL: begin
            if (bus.clear)                                state_d = FLUSH;
            else if (accept && cnt_q == CW'(N - 1))       state_d = RUN;
         end
         RUN: begin
            if (bus.clear)                                state_d = FLUSH;
         end
         FLUSH: begin
            if (bus.fifo_empty && !bus.clear)             state_d = FILL;
         end
         default:                                         state_d = FILL;
      endcase
   end

   // FIFO strobes: push on every accepted sample, pop the oldest in RUN, drain in FLUSH
   always_comb begin
      bus.fifo_wr_en = accept;
      bus.fifo_din   = accept ? bus.din : '0;
      bus.fifo_rd_en = 1'b0;
      case (state_q)
         RUN:     bus.fifo_rd_en = accept;
         FLUSH:   bus.fifo_rd_en = ~bus.fifo_empty;
         default: bus.fifo_rd_en = 1'b0;
      endcase
   end

   // Running sum, count, registered average and sticky underflow flag
   always_comb begin
      sum_d        = sum_q;
      cnt_d        = cnt_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      err_d        = err_q;
      ready_en_d   = 1'b1;
      if (state_q != FLUSH && bus.clear) begin
         sum_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         if (state_q == FILL) begin
            sum_d = sum_q + SW'(bus.din);
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               dout_valid_d = 1'b1;
               dout_d       = sum_d[SW-1:WIN_LOG2];
            end
         end else if (state_q == RUN) begin
            sum_d        = sum_q + SW'(bus.din) - SW'(oldest);
            dout_valid_d = 1'b1;
            dout_d       = sum_d[SW-1:WIN_LOG2];
            if (bus.fifo_empty) err_d = 1'b1;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         sum_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         err_q        <= 1'b0;
         ready_en_q   <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         sum_q        <= sum_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         err_q        <= err_d;
         ready_en_q   <= ready_en_d;
      end
   end

endmodule

// File: tb/tb_moving_avg_ctrl.sv
// Bench for moving_avg_ctrl with N=4: behavioural FWFT FIFO, window model
// checked every cycle, and directed sequences with literal expected averages.
module tb_moving_avg_ctrl;

   localparam int DW    = 8;
   localparam int WL    = 2;
   localparam int FAW   = 3;
   localparam int N     = 4;
   localparam int DEPTH = 8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   moving_avg_ctrl_if #(.DATA_WIDTH(DW)) ifc ();

   moving_avg_ctrl #(
      .DATA_WIDTH     (DW),
      .WIN_LOG2       (WL),
      .FIFO_ADDR_WIDTH(FAW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (ifc),
      .dbg_state(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- external FIFO model (FWFT) ----------------
   logic [DW-1:0] fq[$];
   int            fq_size = 0;
   logic [DW-1:0] fq_head = '0;
   int            wr_cnt = 0;
   int            rd_cnt = 0;

   assign ifc.fifo_dout  = fq_head;
   assign ifc.fifo_empty = (fq_size == 0);
   assign ifc.fifo_full  = (fq_size >= DEPTH);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fq.delete();
         fq_size <= 0;
         fq_head <= '0;
      end else begin
         if (ifc.fifo_rd_en) begin
            rd_cnt++;
            if (fq.size() > 0) void'(fq.pop_front());
         end
         if (ifc.fifo_wr_en) begin
            wr_cnt++;
            if (fq.size() < DEPTH) fq.push_back(ifc.fifo_din);
         end
         fq_size <= fq.size();
         fq_head <= (fq.size() > 0) ? fq[0] : '0;
      end
   end

   // ---------------- window model + per-cycle compare ----------------
   logic [DW-1:0] win_q[$];
   logic [DW-1:0] obs_q[$];
   logic [DW-1:0] exp_dout;
   bit            started, flushing, pend_valid, exp_err;

   always @(negedge clk) begin
      bit exp_ready, accept, exp_rd;
      int total;
      if (!rst_n) begin
         win_q.delete();
         started    = 0;
         flushing   = 0;
         pend_valid = 0;
         exp_err    = 0;
         exp_dout   = '0;
      end else begin
         exp_ready = started && !flushing && !ifc.fifo_full && !ifc.clear;
         accept    = ifc.din_valid && exp_ready;
         exp_rd    = (accept && win_q.size() == N) || (flushing && !ifc.fifo_empty);
         chk("din_ready",  ifc.din_ready,  exp_ready);
         chk("fifo_wr_en", ifc.fifo_wr_en, accept);
         chk("fifo_rd_en", ifc.fifo_rd_en, exp_rd);
         if (accept) chk("fifo_din", ifc.fifo_din, ifc.din);
         chk("dout_valid", ifc.dout_valid, pend_valid);
         chk("dout",       ifc.dout,       exp_dout);
         chk("err",        ifc.err,        exp_err);
         if (ifc.dout_valid) obs_q.push_back(ifc.dout);
         // advance the model to what the next edge should produce
         pend_valid = 0;
         if (flushing) begin
            if (ifc.fifo_empty && !ifc.clear) flushing = 0;
         end else if (ifc.clear) begin
            win_q.delete();
            flushing = 1;
         end else if (accept) begin
            if (win_q.size() == N && ifc.fifo_empty) exp_err = 1;
            win_q.push_back(ifc.din);
            if (win_q.size() > N) void'(win_q.pop_front());
            if (win_q.size() == N) begin
               total = 0;
               foreach (win_q[i]) total += int'(win_q[i]);
               pend_valid = 1;
               exp_dout   = DW'(total / N);
            end
         end
         started = 1;
      end
   end

   // ---------------- driver tasks (start and end at posedge+2) ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send(input logic [DW-1:0] v);
      bit ok;
      ok = 0;
      ifc.din       = v;
      ifc.din_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (ifc.din_ready) ok = 1;
         @(posedge clk);
         #2;
         if (ok) break;
      end
      if (!ok) chk("send_timeout", 32'd0, 32'd1);
      ifc.din_valid = 1'b0;
   endtask

   task automatic chk_obs(input string name, input int exp_n, input int e0, input int e1,
                          input int e2, input int e3, input int e4, input int e5);
      int exp_v[6];
      exp_v = '{e0, e1, e2, e3, e4, e5};
      chk({name, "_count"}, obs_q.size(), exp_n);
      for (int i = 0; i < exp_n && i < obs_q.size(); i++)
         chk(name, obs_q[i], exp_v[i]);
      obs_q.delete();
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int w0, r0;
      ifc.din       = '0;
      ifc.din_valid = 1'b0;
      ifc.clear     = 1'b0;

      // reset
      #1 rst_n = 1'b0;
      #1;
      chk("rst_din_ready",  ifc.din_ready,  0);
      chk("rst_dout",       ifc.dout,       0);
      chk("rst_dout_valid", ifc.dout_valid, 0);
      chk("rst_err",        ifc.err,        0);
      chk("rst_wr_en",      ifc.fifo_wr_en, 0);
      chk("rst_rd_en",      ifc.fifo_rd_en, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      obs_q.delete();

      // 1,2,3,4 -> single output 10>>2 = 2, 4 writes, 0 reads
      w0 = wr_cnt; r0 = rd_cnt;
      send(8'd1); send(8'd2); send(8'd3); send(8'd4);
      idle(2);
      chk_obs("fill_avg", 1, 2, 0, 0, 0, 0, 0);
      chk("fill_writes", wr_cnt - w0, 4);
      chk("fill_reads",  rd_cnt - r0, 0);

      // 8,12 -> 17>>2 = 4, 27>>2 = 6
      w0 = wr_cnt; r0 = rd_cnt;
      send(8'd8); send(8'd12);
      idle(2);
      chk_obs("run_avg", 2, 4, 6, 0, 0, 0, 0);
      chk("run_writes", wr_cnt - w0, 2);
      chk("run_reads",  rd_cnt - r0, 2);

      // 255 x6 after window [3,4,8,12]: 279/4, 530/4, 777/4, then 1020/4
      for (int i = 0; i < 6; i++) send(8'd255);
      idle(2);
      chk_obs("sat_avg", 6, 69, 132, 194, 255, 255, 255);

      // clear with 4 stored: exactly 4 drain reads, then refill 4,4,4,4 -> 4
      r0 = rd_cnt;
      ifc.clear = 1'b1;
      idle(1);
      ifc.clear = 1'b0;
      idle(8);
      chk("flush_reads", rd_cnt - r0, 4);
      send(8'd4); send(8'd4); send(8'd4); send(8'd4);
      idle(2);
      chk_obs("refill_avg", 1, 4, 0, 0, 0, 0, 0);

      // asynchronous reset mid-RUN with din_valid held
      ifc.din       = 8'd77;
      ifc.din_valid = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_din_ready",  ifc.din_ready,  0);
      chk("mid_rst_dout",       ifc.dout,       0);
      chk("mid_rst_dout_valid", ifc.dout_valid, 0);
      chk("mid_rst_err",        ifc.err,        0);
      chk("mid_rst_wr_en",      ifc.fifo_wr_en, 0);
      chk("mid_rst_rd_en",      ifc.fifo_rd_en, 0);
      chk("mid_rst_fifo_din",   ifc.fifo_din,   0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      ifc.din_valid = 1'b0;
      obs_q.delete();
      send(8'd10); send(8'd20); send(8'd30);
      idle(3);
      chk("post_rst_no_output", obs_q.size(), 0);

      // 200 samples with ~50% gaps; every sample now completes a full window
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 1) == 1) idle(1);
         send(DW'($urandom_range(0, 255)));
      end
      idle(3);
      chk("stream_outputs", obs_q.size(), 200);
      chk("stream_err", ifc.err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
